// File: rtl/mem_channel_arbiter.sv
// mem_channel_arbiter: round-robin arbiter sharing one memory read port and
// one memory write port between NUM_CONSUMERS requesters. One transaction is
// in flight at a time. Every output is registered.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// IDLE           | scanning requests from rr_ptr; no transaction in flight
// READ_WAITING   | mem_read_valid held high until mem_read_ready
// WRITE_WAITING  | mem_write_valid held high until mem_write_ready
// READ_RELAYING  | consumer_read_ready[grant_id] held until its read_valid drops
// WRITE_RELAYING | consumer_write_ready[grant_id] held until its write_valid drops
module mem_channel_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  // One extra bit so rr_ptr + offset can exceed N before the wrap.
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                           state_q, state_d;
  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                 grant_id_q, grant_id_d;
  logic                             mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]             mem_read_address_q, mem_read_address_d;
  logic                             mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]             mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]             mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]         read_ready_q, read_ready_d;
  logic [NUM_CONSUMERS-1:0]         write_ready_q, write_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;

  logic             sel_found;
  logic             sel_is_read;
  logic [PTR_W-1:0] sel_id;
  logic [PTR_W-1:0] sel_next_ptr;
  logic [NUM_CONSUMERS-1:0] grant_onehot;

  // Rotating priority scan: first consumer at or after rr_ptr with any request.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    sel_found   = 1'b0;
    sel_is_read = 1'b0;
    sel_id      = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_CONSUMERS)) sum = sum - SUM_W'(NUM_CONSUMERS);
      idx = sum[PTR_W-1:0];
      if (!sel_found && (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
        sel_found   = 1'b1;
        sel_id      = idx;
        sel_is_read = consumer_read_valid[idx];
      end
    end
  end

  // Pointer advances to the consumer after the one just granted, wrapping at N.
  always_comb begin
    logic [SUM_W-1:0] nxt;
    nxt = {1'b0, sel_id} + SUM_W'(1);
    if (nxt >= SUM_W'(NUM_CONSUMERS)) nxt = '0;
    sel_next_ptr = nxt[PTR_W-1:0];
  end

  assign grant_onehot = NUM_CONSUMERS'(1) << grant_id_q;

  // Next-state and registered-output logic; everything holds by default.
  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    grant_id_d          = grant_id_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    read_ready_d        = read_ready_q;
    write_ready_d       = write_ready_q;
    read_data_d         = read_data_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_id_d = sel_id;
          rr_ptr_d   = sel_next_ptr;
          if (sel_is_read) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = consumer_read_address[sel_id*ADDR_BITS +: ADDR_BITS];
            state_d            = READ_WAITING;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = consumer_write_address[sel_id*ADDR_BITS +: ADDR_BITS];
            mem_write_data_d    = consumer_write_data[sel_id*DATA_BITS +: DATA_BITS];
            state_d             = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (mem_read_ready) begin
          mem_read_valid_d = 1'b0;
          read_data_d[grant_id_q*DATA_BITS +: DATA_BITS] = mem_read_data;
          read_ready_d     = grant_onehot;
          state_d          = READ_RELAYING;
        end
      end
      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_write_valid_d = 1'b0;
          write_ready_d     = grant_onehot;
          state_d           = WRITE_RELAYING;
        end
      end
      READ_RELAYING: begin
        if (!consumer_read_valid[grant_id_q]) begin
          read_ready_d = '0;
          state_d      = IDLE;
        end
      end
      WRITE_RELAYING: begin
        if (!consumer_write_valid[grant_id_q]) begin
          write_ready_d = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      rr_ptr_q            <= '0;
      grant_id_q          <= '0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      read_ready_q        <= '0;
      write_ready_q       <= '0;
      read_data_q         <= '0;
    end else begin
      state_q             <= state_d;
      rr_ptr_q            <= rr_ptr_d;
      grant_id_q          <= grant_id_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      read_ready_q        <= read_ready_d;
      write_ready_q       <= write_ready_d;
      read_data_q         <= read_data_d;
    end
  end

  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;
  assign consumer_read_ready  = read_ready_q;
  assign consumer_write_ready = write_ready_q;
  assign consumer_read_data   = read_data_q;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Bench for mem_channel_arbiter: a transaction-level model predicts every
// output each cycle; directed scenarios add literal expectations and check
// the order in which consumers are granted.
module tb_mem_channel_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    rv, wv;
  logic [N*AW-1:0] raddr, waddr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    consumer_read_ready, consumer_write_ready;
  logic [N*DW-1:0] consumer_read_data;
  logic            mem_read_valid, mem_write_valid;
  logic [AW-1:0]   mem_read_address, mem_write_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_read_ready, mem_write_ready;
  logic [DW-1:0]   mem_read_data;

  always #5 clk = ~clk;

  mem_channel_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (raddr),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (wv),
    .consumer_write_address (waddr),
    .consumer_write_data    (wdata),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 free, 1 read issued, 2 write issued, 3 read answered, 4 write answered
  int          m_phase, m_ptr, m_gnt;
  bit          model_live = 1'b0;
  logic        exp_mrv, exp_mwv;
  logic [7:0]  exp_mra, exp_mwa, exp_mwd;
  logic [N-1:0] exp_rr, exp_wr;
  logic [7:0]  exp_rd [N];
  int          grant_log [$];   // consumer id, +16 for a write

  always @(posedge clk) begin
    int i;
    bit found;
    found = 1'b0;
    i = 0;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_gnt = 0;
      exp_mrv = 1'b0; exp_mwv = 1'b0;
      exp_mra = '0; exp_mwa = '0; exp_mwd = '0;
      exp_rr = '0; exp_wr = '0;
      for (int k = 0; k < N; k++) exp_rd[k] = '0;
      model_live = 1'b1;
    end else begin
      case (m_phase)
        0: for (int k = 0; k < N; k++) begin
             i = (m_ptr + k) % N;
             if (!found && (rv[i] || wv[i])) begin
               found = 1'b1;
               m_gnt = i;
               m_ptr = (i + 1) % N;
               if (rv[i]) begin
                 exp_mrv = 1'b1; exp_mra = raddr[i*AW +: AW]; m_phase = 1;
                 grant_log.push_back(i);
               end else begin
                 exp_mwv = 1'b1; exp_mwa = waddr[i*AW +: AW];
                 exp_mwd = wdata[i*DW +: DW]; m_phase = 2;
                 grant_log.push_back(16 + i);
               end
             end
           end
        1: if (mem_read_ready) begin
             exp_mrv = 1'b0; exp_rd[m_gnt] = mem_read_data;
             exp_rr = '0; exp_rr[m_gnt] = 1'b1; m_phase = 3;
           end
        2: if (mem_write_ready) begin
             exp_mwv = 1'b0; exp_wr = '0; exp_wr[m_gnt] = 1'b1; m_phase = 4;
           end
        3: if (!rv[m_gnt]) begin exp_rr = '0; m_phase = 0; end
        4: if (!wv[m_gnt]) begin exp_wr = '0; m_phase = 0; end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare every cycle on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("mem_read_valid", 64'(mem_read_valid), 64'(exp_mrv));
      if (exp_mrv) chk("mem_read_address", 64'(mem_read_address), 64'(exp_mra));
      chk("mem_write_valid", 64'(mem_write_valid), 64'(exp_mwv));
      if (exp_mwv) begin
        chk("mem_write_address", 64'(mem_write_address), 64'(exp_mwa));
        chk("mem_write_data", 64'(mem_write_data), 64'(exp_mwd));
      end
      chk("consumer_read_ready", 64'(consumer_read_ready), 64'(exp_rr));
      chk("consumer_write_ready", 64'(consumer_write_ready), 64'(exp_wr));
      for (int k = 0; k < N; k++)
        chk("consumer_read_data", 64'(consumer_read_data[k*DW +: DW]), 64'(exp_rd[k]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit probe(input int sel);
    case (sel)
      0:       return mem_read_valid;
      1:       return mem_write_valid;
      default: return mem_read_valid | mem_write_valid;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    int n;
    n = 0;
    while (!probe(sel) && n < 50) begin tick(); n++; end
    chk({"wait_", name}, 64'(probe(sel)), 64'(1));
  endtask

  task automatic onehot_id(input logic [N-1:0] v, output int id);
    id = -1;
    for (int k = 0; k < N; k++) if (v[k]) id = k;
  endtask

  task automatic serve_read(input logic [7:0] data, input int lat);
    wait_for(0, "mem_read_valid");
    repeat (lat) tick();
    mem_read_data  = data;
    mem_read_ready = 1'b1;
    tick();
    mem_read_ready = 1'b0;
  endtask

  task automatic serve_any(input logic [7:0] data);
    int g;
    wait_for(2, "mem_any_valid");
    if (mem_read_valid) begin
      mem_read_data = data; mem_read_ready = 1'b1; tick(); mem_read_ready = 1'b0;
      onehot_id(consumer_read_ready, g);
      if (g >= 0) rv[g] = 1'b0;
    end else begin
      mem_write_ready = 1'b1; tick(); mem_write_ready = 1'b0;
      onehot_id(consumer_write_ready, g);
      if (g >= 0) wv[g] = 1'b0;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int rr_exp [5] = '{0, 1, 2, 3, 0};
  int pr_exp [4] = '{1, 18, 0, 17};

  initial begin
    int g, cnt;
    reset = 1'b1; rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_mem_read_valid", 64'(mem_read_valid), 64'(0));
    chk("reset_read_data", 64'(consumer_read_data), 64'(0));

    // Reset during READ_WAITING abandons the read.
    rv[1] = 1'b1; raddr[1*AW +: AW] = 8'h55;
    wait_for(0, "mem_read_valid");
    reset = 1'b1; rv = '0;
    tick();
    reset = 1'b0;
    chk("rst_mid_mem_read_valid", 64'(mem_read_valid), 64'(0));
    chk("rst_mid_read_ready", 64'(consumer_read_ready), 64'(0));
    mem_read_data = 8'hEE; mem_read_ready = 1'b1;
    repeat (2) begin
      tick();
      chk("rst_late_read_ready", 64'(consumer_read_ready), 64'(0));
    end
    mem_read_ready = 1'b0;

    // Single read: consumer 2, addr 0x3C, data 0xA5 after two cycles.
    rv[2] = 1'b1; raddr[2*AW +: AW] = 8'h3C;
    wait_for(0, "mem_read_valid");
    chk("single_read_addr", 64'(mem_read_address), 64'(8'h3C));
    repeat (2) tick();
    mem_read_data = 8'hA5; mem_read_ready = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    chk("single_read_ready", 64'(consumer_read_ready), 64'(4'b0100));
    chk("single_read_data", 64'(consumer_read_data[2*DW +: DW]), 64'(8'hA5));
    chk("single_read_valid_low", 64'(mem_read_valid), 64'(0));
    repeat (2) tick();
    chk("single_read_ready_held", 64'(consumer_read_ready), 64'(4'b0100));
    rv[2] = 1'b0;
    tick();
    chk("single_read_ready_drop", 64'(consumer_read_ready), 64'(0));
    chk("single_read_data_kept", 64'(consumer_read_data[2*DW +: DW]), 64'(8'hA5));

    // Single write: consumer 0 writes 0x77 to 0x10.
    wv[0] = 1'b1; waddr[0 +: AW] = 8'h10; wdata[0 +: DW] = 8'h77;
    wait_for(1, "mem_write_valid");
    chk("single_write_addr", 64'(mem_write_address), 64'(8'h10));
    chk("single_write_data", 64'(mem_write_data), 64'(8'h77));
    repeat (3) tick();
    chk("single_write_held", 64'(mem_write_valid), 64'(1));
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    chk("single_write_ready", 64'(consumer_write_ready), 64'(4'b0001));
    chk("single_write_valid_low", 64'(mem_write_valid), 64'(0));
    wv[0] = 1'b0;
    tick();
    chk("single_write_ready_drop", 64'(consumer_write_ready), 64'(0));

    // Round-robin from a fresh pointer: all four read continuously.
    reset = 1'b1; tick(); reset = 1'b0;
    grant_log.delete();
    raddr = {8'h13, 8'h12, 8'h11, 8'h10};
    rv = 4'hF;
    for (int t = 0; t < 5; t++) begin
      serve_read(8'hB0 + 8'(t), 1);
      onehot_id(consumer_read_ready, g);
      if (g >= 0) begin
        rv[g] = 1'b0;
        tick();
        if (t < 4) rv[g] = 1'b1;
      end
    end
    rv = '0;
    tick();
    chk("rr_count", 64'(grant_log.size()), 64'(5));
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) chk("rr_order", 64'(grant_log[k]), 64'(rr_exp[k]));

    // Read beats write on consumer 1; pointer starts at 1 after the last grant.
    grant_log.delete();
    raddr[0 +: AW] = 8'h20; raddr[1*AW +: AW] = 8'h21;
    waddr[1*AW +: AW] = 8'h31; wdata[1*DW +: DW] = 8'hC1;
    waddr[2*AW +: AW] = 8'h32; wdata[2*DW +: DW] = 8'hC2;
    rv = 4'b0011; wv = 4'b0110;
    for (int t = 0; t < 4; t++) serve_any(8'hD0 + 8'(t));
    chk("prio_count", 64'(grant_log.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) chk("prio_order", 64'(grant_log[k]), 64'(pr_exp[k]));

    // Early drop: consumer 3 abandons valid while the write is outstanding.
    wv[3] = 1'b1; waddr[3*AW +: AW] = 8'h3F; wdata[3*DW +: DW] = 8'h5A;
    wait_for(1, "mem_write_valid");
    wv[3] = 1'b0;
    chk("early_write_addr", 64'(mem_write_address), 64'(8'h3F));
    chk("early_write_data", 64'(mem_write_data), 64'(8'h5A));
    repeat (2) tick();
    chk("early_write_held", 64'(mem_write_valid), 64'(1));
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    cnt = 0;
    repeat (4) begin
      if (consumer_write_ready[3]) cnt++;
      tick();
    end
    chk("early_drop_pulse_len", 64'(cnt), 64'(1));

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_channel_arbiter.md
# mem_channel_arbiter

- Round-robin arbiter that shares one external memory channel (one read port, one write port) between `NUM_CONSUMERS` requesters inside a compute core: per-thread LSUs and the instruction fetcher.
- Accepts one transaction at a time, relays it to memory and returns the response to the granted consumer.
- Its completion feeds the core controller's WAIT/FETCH stalls.

## Interface
- `NUM_CONSUMERS`, 4, number of requesters (1..8)
- `ADDR_BITS`, 8, address width
- `DATA_BITS`, 8, data width
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `consumer_read_valid` in N: per-consumer read request, held until its ready is seen
- `consumer_read_address` in N*ADDR_BITS: packed, consumer i at bits [i*ADDR_BITS +: ADDR_BITS]
- `consumer_read_ready` out N: read response valid for consumer i
- `consumer_read_data` out N*DATA_BITS: packed read data
- `consumer_write_valid` in N: per-consumer write request
- `consumer_write_address` in N*ADDR_BITS: packed
- `consumer_write_data` in N*DATA_BITS: packed
- `consumer_write_ready` out N: write acknowledge
- `mem_read_valid` out 1, `mem_read_address` out ADDR_BITS: read request to memory
- `mem_read_ready` in 1, `mem_read_data` in DATA_BITS: memory read response
- `mem_write_valid` out 1, `mem_write_address` out ADDR_BITS, `mem_write_data` out DATA_BITS: write request to memory
- `mem_write_ready` in 1: memory write acknowledge

## Operation
- States: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- Registers: `rr_ptr` (max(1,clog2 N) bits) and `grant_id`.

**IDLE**
- Scan i = rr_ptr, rr_ptr+1, … mod N. Select the first i with read_valid or write_valid.
- Read beats write on the same consumer.
- On selection:
  - latch `grant_id` = i;
  - for a read, drive `mem_read_valid`=1 and `mem_read_address`=consumer i's address, then go to READ_WAITING;
  - for a write, drive `mem_write_valid`=1 with address and data, then go to WRITE_WAITING;
  - set `rr_ptr` = (i+1) mod N.
- With no request, stay in IDLE.
- `mem_*_ready` is ignored in IDLE and RELAYING states.

**READ_WAITING**
- On `mem_read_ready`=1:
  - `mem_read_valid`←0;
  - `consumer_read_data[grant_id]`←`mem_read_data`;
  - `consumer_read_ready[grant_id]`←1;
  - go to READ_RELAYING.
- Memory latency is unbounded; address and valid are held stable until ready.

**WRITE_WAITING**
- On `mem_write_ready`=1: `mem_write_valid`←0, `consumer_write_ready[grant_id]`←1, go to WRITE_RELAYING.

**READ_RELAYING / WRITE_RELAYING**
- Hold ready (and data) until the granted consumer's matching valid is sampled 0.
- Then clear ready and go to IDLE.

**General rules**
- Only one consumer ready bit is high at any time.
- `consumer_read_data[i]` retains its last value after ready drops.
- A consumer dropping valid during WAITING does not cancel the memory transaction. Ready still pulses for exactly one cycle, because RELAYING sees valid low at its first edge.
- Requests from other consumers during a transaction are not lost; they stay pending (valid held) and are arbitrated in the next IDLE.
- Fairness: with all N consumers requesting continuously, each is served once per N grants.

## Timing
- Reset: every output 0, `rr_ptr`=0, `grant_id`=0, state IDLE. Reset mid-transaction abandons it immediately; no ready pulse is produced afterwards.
- Request sampled at edge t → `mem_*_valid` high after edge t (1-cycle grant latency).
- `mem_*_ready` sampled at edge k → consumer ready high after edge k, `mem_*_valid` low after edge k.
- Consumer valid sampled low at edge m → ready low after edge m, state IDLE. The next grant is sampled at the earliest at edge m+1.
- Minimum transaction, with memory ready 1 cycle after valid and the consumer dropping valid immediately: 4 cycles from valid to IDLE.
- Memory outputs are registered; no combinational path from any input to any output.

## Test plan
- **Reset:** assert reset while in READ_WAITING → next cycle all outputs 0 and state IDLE; memory ready arriving afterwards produces no consumer ready.
- **Single read:** consumer 2 reads addr 0x3C; memory returns 0xA5 two cycles later → `mem_read_address`=0x3C, `consumer_read_data[2]`=0xA5, `consumer_read_ready`=4'b0100 until consumer 2 drops valid.
- **Single write:** consumer 0 writes 0x77 to 0x10 → `mem_write_valid` with 0x10/0x77 held until `mem_write_ready`; then `consumer_write_ready`=4'b0001 for the relay.
- **Round-robin:** all 4 consumers assert read simultaneously and re-assert after each completion → grant order 0,1,2,3,0; no consumer is served twice before the others.
- **Read/write priority:** consumer 1 asserts read and write together → read served first, write served on a later grant; other consumers pending at 0 and 2 are interleaved per `rr_ptr`.
- **Early drop:** consumer 3 drops valid during WRITE_WAITING → the memory write still completes and `consumer_write_ready[3]` is high for exactly one cycle.
